// File: rtl/reg_serial_reader_if.sv
// Handshake bundle for reg_serial_reader: parallel load side plus the serial
// valid/ready stream. Names carry the direction as seen from the reader.
interface reg_serial_reader_if #(
  parameter int W = 8
);
  logic         i_load;
  logic [W-1:0] i_d;
  logic         i_sready;
  logic         o_sdata;
  logic         o_svalid;
  logic         o_busy;
  logic         o_done;

  modport master (
    output i_load, i_d, i_sready,
    input  o_sdata, o_svalid, o_busy, o_done
  );

  modport slave (
    input  i_load, i_d, i_sready,
    output o_sdata, o_svalid, o_busy, o_done
  );
endinterface

// File: rtl/reg_serial_reader.sv
// Parallel-to-serial reader: captures a W-bit word on load and streams it out
// one bit per valid/ready handshake, then pulses done for one cycle.
module reg_serial_reader #(
  parameter int W         = 8,
  parameter bit MSB_FIRST = 1'b1,
  parameter bit IDLE_BIT  = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  reg_serial_reader_if.slave bus
);
  localparam int            CW   = $clog2(W);
  localparam logic [CW-1:0] LAST = CW'(W - 1);
  localparam logic [CW-1:0] ONE  = CW'(32'd1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_t;

  state_t        r_state;
  state_t        w_state_nxt;
  logic [W-1:0]  r_sr;
  logic [W-1:0]  w_sr_nxt;
  logic [CW-1:0] r_cnt;
  logic [CW-1:0] w_cnt_nxt;
  logic          w_accept;
  logic          r_sdata;
  logic          r_svalid;
  logic          r_busy;
  logic          r_done;
  logic          w_sdata_nxt;
  logic          w_svalid_nxt;
  logic          w_busy_nxt;
  logic          w_done_nxt;

  // svalid is registered high exactly while in SHIFT, so state stands in for it
  assign w_accept = (r_state == S_SHIFT) && bus.i_sready;

  // State register
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (bus.i_load) w_state_nxt = S_SHIFT;
        else            w_state_nxt = S_IDLE;
      end
      S_SHIFT: begin
        if (w_accept && (r_cnt == LAST)) w_state_nxt = S_DONE;
        else                             w_state_nxt = S_SHIFT;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Shift register and bit counter next values
  always_comb begin
    w_sr_nxt  = r_sr;
    w_cnt_nxt = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (bus.i_load) begin
          w_sr_nxt  = bus.i_d;
          w_cnt_nxt = '0;
        end else begin
          w_sr_nxt  = r_sr;
          w_cnt_nxt = r_cnt;
        end
      end
      S_SHIFT: begin
        if (w_accept) begin
          if (MSB_FIRST) w_sr_nxt = {r_sr[W-2:0], 1'b0};
          else           w_sr_nxt = {1'b0, r_sr[W-1:1]};
          if (r_cnt == LAST) w_cnt_nxt = '0;
          else               w_cnt_nxt = r_cnt + ONE;
        end else begin
          w_sr_nxt  = r_sr;
          w_cnt_nxt = r_cnt;
        end
      end
      default: begin
        w_sr_nxt  = r_sr;
        w_cnt_nxt = r_cnt;
      end
    endcase
  end

  // Shift register and counter storage
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sr  <= '0;
      r_cnt <= '0;
    end else begin
      r_sr  <= w_sr_nxt;
      r_cnt <= w_cnt_nxt;
    end
  end

  // Outputs decoded from the upcoming state so the registered copies line up with it
  always_comb begin
    w_sdata_nxt  = IDLE_BIT;
    w_svalid_nxt = 1'b0;
    w_busy_nxt   = 1'b0;
    w_done_nxt   = 1'b0;
    case (w_state_nxt)
      S_SHIFT: begin
        w_svalid_nxt = 1'b1;
        w_busy_nxt   = 1'b1;
        if (MSB_FIRST) w_sdata_nxt = w_sr_nxt[W-1];
        else           w_sdata_nxt = w_sr_nxt[0];
      end
      S_DONE:  w_done_nxt = 1'b1;
      S_IDLE:  w_sdata_nxt = IDLE_BIT;
      default: w_sdata_nxt = IDLE_BIT;
    endcase
  end

  // Output registers
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_sdata  <= IDLE_BIT;
      r_svalid <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else begin
      r_sdata  <= w_sdata_nxt;
      r_svalid <= w_svalid_nxt;
      r_busy   <= w_busy_nxt;
      r_done   <= w_done_nxt;
    end
  end

  assign bus.o_sdata  = r_sdata;
  assign bus.o_svalid = r_svalid;
  assign bus.o_busy   = r_busy;
  assign bus.o_done   = r_done;
endmodule

// File: doc/reg_serial_reader.md
REG_SERIAL_READER -- requirements
Module: reg_serial_reader

Interface
REQ-001 Parameter W, default 8, SHALL set the parallel word width (W >= 2).
REQ-002 Parameter MSB_FIRST, default 1, SHALL select the serial bit order: 1 = bit W-1 first, 0 = bit 0 first.
REQ-003 Parameter IDLE_BIT, default 0, SHALL set the sdata value whenever no bit is being presented.
REQ-004 clk  input  1  SHALL be the clock; all state SHALL update on its rising edge.
REQ-005 rst  input  1  SHALL be the reset: asynchronous, active-low.
REQ-006 load  input  1  SHALL request capture of D and start of a serial read-out.
REQ-007 D  input  W  SHALL be the parallel word, sampled only on an accepted load.
REQ-008 sdata  output  1  SHALL be the current serial bit.
REQ-009 svalid  output  1  SHALL be high while sdata holds a valid bit.
REQ-010 sready  input  1  SHALL be the downstream acceptance of the current bit.
REQ-011 busy  output  1  SHALL be high from an accepted load until done is asserted, excluding the done cycle.
REQ-012 done  output  1  SHALL be a single-cycle pulse marking completion of a word.

Function
REQ-013 The block SHALL implement the FSM states IDLE, SHIFT and DONE.
REQ-014 IDLE: svalid=0, busy=0, done=0, sdata=IDLE_BIT.
REQ-015 IDLE with load=1 SHALL capture D into the shift register, clear the bit counter and enter SHIFT on the next edge.
REQ-016 SHIFT: svalid=1, busy=1, sdata = shift-register MSB if MSB_FIRST=1, else LSB.
REQ-017 A bit SHALL be accepted only on an edge where svalid=1 and sready=1; on acceptance the register SHALL shift by one toward the output end and the counter SHALL increment.
REQ-018 While sready=0 in SHIFT, sdata, the counter and the register SHALL hold unchanged for any number of cycles.
REQ-019 The counter SHALL be $clog2(W) bits wide and SHALL count accepted bits 0..W-1.
REQ-020 Acceptance with counter=W-1 SHALL transition SHIFT to DONE; no further bit SHALL be presented.
REQ-021 DONE SHALL last exactly one cycle with done=1, svalid=0, busy=0, then return to IDLE.
REQ-022 load SHALL be ignored in SHIFT and DONE; D changes outside the capture edge SHALL have no effect.
REQ-023 load in DONE SHALL NOT start a new word; a word started by load in the first IDLE cycle after DONE SHALL present its first bit two cycles after the prior done pulse.
REQ-024 Latency: the first bit SHALL appear on sdata with svalid=1 in the cycle after the load edge; with sready held high, done SHALL assert W+1 cycles after the load edge.
REQ-025 Exactly W bits SHALL be emitted per load, each exactly once, in the order set by MSB_FIRST.

Reset
REQ-026 rst=0 SHALL asynchronously force state=IDLE, counter=0, shift register=0, svalid=0, busy=0, done=0, sdata=IDLE_BIT.
REQ-027 rst asserted mid-word SHALL abort the word; no done pulse SHALL follow, and after release the block SHALL wait in IDLE for a new load.
REQ-028 The first load SHALL be accepted on the first rising edge with rst=1.

Verification
REQ-029 W=8, MSB_FIRST=1, D=8'hA5, load 1 cycle, sready=1 -> sdata 1,0,1,0,0,1,0,1 on 8 consecutive cycles; done pulses once 9 cycles after load.
REQ-030 W=8, MSB_FIRST=0, D=8'hA5 -> sdata 1,0,1,0,0,1,0,1 (LSB first); busy high for exactly 8 cycles.
REQ-031 D=8'hF0, sready low 3 cycles after bit 2 -> bit 2 (value 1) held with svalid=1 for 4 cycles; total 8 bits emitted, done delayed by 3 cycles.
REQ-032 load re-pulsed with D=8'h00 during SHIFT of 8'hFF -> output stream remains all ones; one done pulse only.
REQ-033 rst pulsed low after 4 bits of 8'h3C -> outputs reach reset values immediately; no done; a new load of 8'h81 then emits 1,0,0,0,0,0,0,1.
REQ-034 load held high continuously with sready=1 -> words back-to-back with one DONE and one IDLE cycle between words; each word D sampled at its own capture edge.
